spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first) that drives the FPGA SPI slave/ALU datapath.
//  Each frame carries one 8-bit word: operand1 in [7:4], operand2 in [3:0].
//  Full duplex: it shifts tx_data out on mosi and captures miso into rx_data.
//  It generates sck and cs_n from the system clock, with an optional slave_ready handshake.
// PARAMETERS
//  DATA_W     8   frame length in bits
//  CLK_DIV    2   clk cycles per sck half-period (>=1)
//  USE_READY  0   1: wait for slave_ready before the first sck edge
//  TIMEOUT    16  max clk cycles to wait for slave_ready (>=1)
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  rst          in   1       async active-low reset
//  start        in   1       request a frame; sampled only while busy=0
//  tx_data      in   DATA_W  word to send; latched on the accept cycle
//  miso         in   1       serial data from slave
//  slave_ready  in   1       slave ready flag (async; 2-FF synchronised)
//  sck          out  1       SPI clock, idles low
//  cs_n         out  1       chip select, active low
//  mosi         out  1       serial data to slave
//  busy         out  1       frame in progress or inter-frame gap
//  done         out  1       1-cycle pulse at frame end; rx_data valid
//  err          out  1       1-cycle pulse with done on ready timeout
//  rx_data      out  DATA_W  last received word; held until the next done
// BEHAVIOUR
//  Reset (rst=0, async): sck=0, cs_n=1, mosi=0, busy=0, done=0, err=0, rx_data=0, FSM=IDLE.
//   A reset in mid-frame aborts the frame at once. No done pulse is produced.
//  FSM: IDLE -> (WAIT_RDY) -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: start=1 at cycle 0 -> accept. Latch tx_data into the shift register.
//   From cycle 1: cs_n=0, busy=1, mosi=tx_data[DATA_W-1].
//  WAIT_RDY (USE_READY=1 only): sck=0, cs_n=0.
//   Exit to SETUP on the first cycle the synchronised slave_ready=1.
//   If TIMEOUT cycles pass without ready: cs_n=1, done=1 and err=1 for one cycle, rx_data unchanged, go to GAP.
//  SETUP: CLK_DIV cycles, sck=0 (mosi setup time before the first rising edge).
//  SHIFT: DATA_W bits. Per bit, sck=1 for CLK_DIV cycles, then sck=0 for CLK_DIV cycles.
//   miso is sampled on the clk edge that ends the sck-high phase. This tolerates the slave's registered miso.
//   mosi advances to the next bit on the sck falling transition.
//   After the last bit, mosi holds the LSB.
//  HOLD: CLK_DIV cycles, sck=0, cs_n=0.
//  GAP: first cycle has cs_n=1, done=1, rx_data updated (bits received MSB first).
//   busy stays 1 for CLK_DIV cycles total, then returns to IDLE with busy=0.
//  Timing with USE_READY=0: done is at cycle 18*CLK_DIV+1 (DATA_W=8), busy falls at cycle 19*CLK_DIV+1.
//   In general: done at (2*DATA_W+2)*CLK_DIV+1.
//  start while busy=1 is ignored, with no queueing. tx_data changes after accept are ignored.
//  start held high: back-to-back frames with cs_n high for at least CLK_DIV cycles between them.
//  Exactly DATA_W rising sck edges per completed frame, 0 on timeout.
//  sck, cs_n and mosi are driven directly from registers (glitch-free).
//  The divider counter reloads at each phase change. There is no wrap-around dependency between frames.
// TESTING
//  1 CLK_DIV=2, tx_data=0xA5, miso looped back from mosi -> rx_data=0xA5, done at cycle 37, 8 sck rises, busy low at cycle 39.
//  2 Slave model returns 0x3C, tx_data=0x5E -> mosi bits 0,1,0,1,1,1,1,0 at sck rises; rx_data=0x3C; err=0.
//  3 start held high, then pulsed again mid-frame -> the mid-frame pulse is ignored; cs_n high >=2 cycles between frames; each frame has 1 done.
//  4 rst=0 during bit 4 -> sck=0, cs_n=1, busy=0 immediately, no done; next start (tx 0x81) -> rx correct.
//  5 USE_READY=1, TIMEOUT=16, slave_ready=0 -> done+err pulse, cs_n rises, 0 sck edges; with ready raised at cycle 5 -> normal frame, err=0.
//  6 CLK_DIV=1, frames 0xFF then 0x00 -> sck period 2 clk, done at cycle 19 per frame, rx matches loopback.

Source files
------------

// File: rtl/spi_master_if.sv
// Bus bundle between an SPI mode-0 master and the logic that drives it.
// The master modport is the controller's view; slave is the requester/pin side.
`timescale 1ns/1ps
interface spi_master_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              miso;
  logic              slave_ready;
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rx_data;

  modport master (
    input  start, tx_data, miso, slave_ready,
    output sck, cs_n, mosi, busy, done, err, rx_data
  );

  modport slave (
    output start, tx_data, miso, slave_ready,
    input  sck, cs_n, mosi, busy, done, err, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first), one DATA_W-bit full-duplex word per frame.
// sck/cs_n/mosi come straight from flops; optional slave_ready wait with timeout.
`timescale 1ns/1ps
module spi_master #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int CNT_MAX = (CLK_DIV > TIMEOUT) ? CLK_DIV : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SETUP    = 3'd2,
    SHIFT    = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              sck_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] sr;
  logic              rdy_p0;
  logic              rdy_p1;

  logic phase_end;
  logic accept;
  logic shift_en;

  assign phase_end = (cnt == DIV_LAST);
  assign accept    = (state == IDLE) && bus.start;
  // miso is captured on the edge that ends the sck-high phase, same edge that drops sck.
  assign shift_en  = (state == SHIFT) && sck_q && phase_end;

  // slave_ready synchroniser, stage 0 -> stage 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_p0 <= 1'b0;
      rdy_p1 <= 1'b0;
    end else begin
      rdy_p0 <= bus.slave_ready;
      rdy_p1 <= rdy_p0;
    end
  end

  // Shift register: loads on accept, shifts miso in from the LSB end each bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      sr <= bus.tx_data;
    end else if (shift_en) begin
      sr <= {sr[DATA_W-2:0], bus.miso};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mosi_q <= bus.tx_data[DATA_W-1];
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
            cnt    <= '0;
            state  <= (USE_READY != 0) ? WAIT_RDY : SETUP;
          end
        end
        WAIT_RDY: begin
          if (rdy_p1) begin
            cnt   <= '0;
            state <= SETUP;
          end else if (cnt == TO_LAST) begin
            cs_n_q <= 1'b1;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SETUP: begin
          if (phase_end) begin
            sck_q   <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHIFT: begin
          if (phase_end) begin
            cnt <= '0;
            if (sck_q) begin
              sck_q <= 1'b0;
              // The LSB stays on mosi after the final falling edge.
              if (bit_cnt != BIT_LAST) begin
                mosi_q <= sr[DATA_W-2];
              end
            end else if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              sck_q   <= 1'b1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (phase_end) begin
            cs_n_q <= 1'b1;
            done_q <= 1'b1;
            rx_q   <= sr;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          sck_q  <= 1'b0;
          cs_n_q <= 1'b1;
          busy_q <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sck     = sck_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV=2, CLK_DIV=2 with ready handshake, CLK_DIV=1)
// driven from a vector table, hand-written corner sequences and random frames vs a slave model.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(8)) bus_a ();
  spi_master_if #(.DATA_W(8)) bus_b ();
  spi_master_if #(.DATA_W(8)) bus_c ();

  spi_master #(.DATA_W(8), .CLK_DIV(2), .USE_READY(0), .TIMEOUT(16))
    u_a (.clk(clk), .rst(rst), .bus(bus_a));
  spi_master #(.DATA_W(8), .CLK_DIV(2), .USE_READY(1), .TIMEOUT(16))
    u_b (.clk(clk), .rst(rst), .bus(bus_b));
  spi_master #(.DATA_W(8), .CLK_DIV(1), .USE_READY(0), .TIMEOUT(16))
    u_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Per-instance stimulus and observation arrays, index 0=a, 1=b, 2=c.
  logic       start_v[3];
  logic [7:0] tx_v[3];
  logic [7:0] resp_v[3];
  logic       loop_v[3];
  logic       rdy_v[3];
  logic       slave_bit[3];
  logic       sck_v[3], cs_n_v[3], mosi_v[3], busy_v[3], done_v[3], err_v[3];
  logic [7:0] rx_v[3];

  assign bus_a.start = start_v[0];   assign bus_b.start = start_v[1];   assign bus_c.start = start_v[2];
  assign bus_a.tx_data = tx_v[0];    assign bus_b.tx_data = tx_v[1];    assign bus_c.tx_data = tx_v[2];
  assign bus_a.slave_ready = rdy_v[0];
  assign bus_b.slave_ready = rdy_v[1];
  assign bus_c.slave_ready = rdy_v[2];
  assign bus_a.miso = loop_v[0] ? bus_a.mosi : slave_bit[0];
  assign bus_b.miso = loop_v[1] ? bus_b.mosi : slave_bit[1];
  assign bus_c.miso = loop_v[2] ? bus_c.mosi : slave_bit[2];

  assign sck_v[0] = bus_a.sck;   assign sck_v[1] = bus_b.sck;   assign sck_v[2] = bus_c.sck;
  assign cs_n_v[0] = bus_a.cs_n; assign cs_n_v[1] = bus_b.cs_n; assign cs_n_v[2] = bus_c.cs_n;
  assign mosi_v[0] = bus_a.mosi; assign mosi_v[1] = bus_b.mosi; assign mosi_v[2] = bus_c.mosi;
  assign busy_v[0] = bus_a.busy; assign busy_v[1] = bus_b.busy; assign busy_v[2] = bus_c.busy;
  assign done_v[0] = bus_a.done; assign done_v[1] = bus_b.done; assign done_v[2] = bus_c.done;
  assign err_v[0] = bus_a.err;   assign err_v[1] = bus_b.err;   assign err_v[2] = bus_c.err;
  assign rx_v[0] = bus_a.rx_data; assign rx_v[1] = bus_b.rx_data; assign rx_v[2] = bus_c.rx_data;

  // Slave model: presents resp MSB first, bit index advances on each sck fall while selected.
  int         idx_v[3]   = '{0, 0, 0};
  int         rises_v[3] = '{0, 0, 0};
  logic       prev_sck[3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] mcap_v[3]  = '{8'h00, 8'h00, 8'h00};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      slave_bit[i] = 1'b0;
      if (idx_v[i] < 8) slave_bit[i] = resp_v[i][3'(7 - idx_v[i])];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      prev_sck[i] <= sck_v[i];
      if (!rst || cs_n_v[i]) idx_v[i] <= 0;
      else if (prev_sck[i] && !sck_v[i]) idx_v[i] <= idx_v[i] + 1;
      if (!prev_sck[i] && sck_v[i]) begin
        rises_v[i] <= rises_v[i] + 1;
        mcap_v[i]  <= {mcap_v[i][6:0], mosi_v[i]};
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame on instance i; cycle 0 is the cycle whose closing edge accepts start.
  task automatic run_frame(input int i, input logic [7:0] tx, input logic [7:0] resp,
                           input bit loopb, input int rdy_at,
                           output int d_cyc, output int b_cyc, output logic [7:0] rx,
                           output bit errf, output int nrise, output logic [7:0] mcap,
                           output int ndone, output logic mosi_done);
    int r0;
    @(negedge clk);
    tx_v[i] = tx; resp_v[i] = resp; loop_v[i] = loopb; start_v[i] = 1'b1;
    r0 = rises_v[i];
    d_cyc = -1; b_cyc = -1; ndone = 0; errf = 1'b0; rx = 8'h00; mosi_done = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start_v[i] = 1'b0;
      if (done_v[i]) begin
        ndone++;
        if (d_cyc < 0) begin
          d_cyc = n; rx = rx_v[i]; errf = err_v[i]; mosi_done = mosi_v[i];
        end
      end
      if (n == rdy_at) rdy_v[i] = 1'b1;
      if (!busy_v[i]) begin
        b_cyc = n;
        break;
      end
    end
    nrise = rises_v[i] - r0;
    mcap = mcap_v[i];
    rdy_v[i] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] tx;
    logic [7:0] resp;
    bit         loopb;
    int         rdy_at;
    logic [7:0] exp_rx;
    bit         exp_err;
    int         exp_rises;
    int         exp_done;
    int         exp_busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int d_cyc, b_cyc, nrise, ndone, dones, d1, d2, cs_falls, hi_run, min_gap, cd;
    logic [7:0] rx, mcap, rx1, rx2, t, r;
    bit errf;
    logic mosi_done, prev_cs;

    tbl[0] = '{0, 8'hA5, 8'h00, 1'b1, -1, 8'hA5, 1'b0, 8, 37, 39};
    tbl[1] = '{0, 8'h5E, 8'h3C, 1'b0, -1, 8'h3C, 1'b0, 8, 37, 39};
    tbl[2] = '{1, 8'h69, 8'h96, 1'b0,  5, 8'h96, 1'b0, 8, 44, 46};
    tbl[3] = '{1, 8'h12, 8'h77, 1'b0, -1, 8'h96, 1'b1, 0, 17, 19};
    tbl[4] = '{2, 8'hFF, 8'h00, 1'b1, -1, 8'hFF, 1'b0, 8, 19, 20};
    tbl[5] = '{2, 8'h00, 8'hFF, 1'b1, -1, 8'h00, 1'b0, 8, 19, 20};

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; tx_v[i] = 8'h00; resp_v[i] = 8'h00; loop_v[i] = 1'b0; rdy_v[i] = 1'b0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sck", sck_v[0], 1'b0);
    check("rst_cs_n", cs_n_v[0], 1'b1);
    check("rst_mosi", mosi_v[0], 1'b0);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_done", done_v[0], 1'b0);
    check("rst_err", err_v[0], 1'b0);
    check("rst_rx", rx_v[0], 8'h00);
    check("rst_cs_n_b", cs_n_v[1], 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Directed vectors from the table.
    for (int k = 0; k < 6; k++) begin
      run_frame(tbl[k].inst, tbl[k].tx, tbl[k].resp, tbl[k].loopb, tbl[k].rdy_at,
                d_cyc, b_cyc, rx, errf, nrise, mcap, ndone, mosi_done);
      check($sformatf("v%0d_done_cyc", k), d_cyc, tbl[k].exp_done);
      check($sformatf("v%0d_busy_cyc", k), b_cyc, tbl[k].exp_busy);
      check($sformatf("v%0d_rx", k), rx, tbl[k].exp_rx);
      check($sformatf("v%0d_err", k), errf, tbl[k].exp_err);
      check($sformatf("v%0d_rises", k), nrise, tbl[k].exp_rises);
      check($sformatf("v%0d_ndone", k), ndone, 1);
      if (tbl[k].exp_rises == 8) begin
        check($sformatf("v%0d_mosi_bits", k), mcap, tbl[k].tx);
        check($sformatf("v%0d_mosi_lsb_hold", k), mosi_done, tbl[k].tx[0]);
      end
    end

    // Start held high across frames, a stray pulse mid-frame, tx changes after accept.
    @(negedge clk);
    loop_v[0] = 1'b1; tx_v[0] = 8'hC3; start_v[0] = 1'b1;
    @(posedge clk);
    dones = 0; d1 = -1; d2 = -1; rx1 = 8'h00; rx2 = 8'h00;
    cs_falls = 1; hi_run = 0; min_gap = 1000; prev_cs = 1'b0;
    for (int n = 1; n <= 130; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        dones++;
        if (dones == 1) begin d1 = n; rx1 = rx_v[0]; end
        else if (dones == 2) begin d2 = n; rx2 = rx_v[0]; end
      end
      if (cs_n_v[0]) hi_run++;
      else begin
        if (prev_cs) begin
          cs_falls++;
          if (hi_run < min_gap) min_gap = hi_run;
        end
        hi_run = 0;
      end
      prev_cs = cs_n_v[0];
      if (n == 10) tx_v[0] = 8'h5A;
      if (n == 45) start_v[0] = 1'b0;
      if (n == 50) tx_v[0] = 8'hFF;
      if (n == 60) start_v[0] = 1'b1;
      if (n == 61) start_v[0] = 1'b0;
    end
    check("held_dones", dones, 2);
    check("held_done1_cyc", d1, 37);
    check("held_rx1", rx1, 8'hC3);
    check("held_done2_cyc", d2, 76);
    check("held_rx2", rx2, 8'h5A);
    check("held_cs_frames", cs_falls, 2);
    check("held_gap_ge_div", (min_gap >= 2) ? 1 : 0, 1);
    check("held_idle_after", busy_v[0], 1'b0);

    // Reset during bit 4 aborts the frame with no done.
    @(negedge clk);
    loop_v[0] = 1'b1; tx_v[0] = 8'h3C; start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("abort_sck", sck_v[0], 1'b0);
    check("abort_cs_n", cs_n_v[0], 1'b1);
    check("abort_busy", busy_v[0], 1'b0);
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 3) rst = 1'b1;
      if (done_v[0]) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_rx_cleared", rx_v[0], 8'h00);
    run_frame(0, 8'h81, 8'h00, 1'b1, -1, d_cyc, b_cyc, rx, errf, nrise, mcap, ndone, mosi_done);
    check("after_abort_rx", rx, 8'h81);
    check("after_abort_done_cyc", d_cyc, 37);
    check("after_abort_rises", nrise, 8);

    // Random frames vs slave model; expectations from the frame-timing arithmetic.
    for (int k = 0; k < 12; k++) begin
      int inst;
      inst = (k < 8) ? 0 : 2;
      cd = (inst == 2) ? 1 : 2;
      t = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      run_frame(inst, t, r, 1'b0, -1, d_cyc, b_cyc, rx, errf, nrise, mcap, ndone, mosi_done);
      check($sformatf("rnd%0d_rx", k), rx, r);
      check($sformatf("rnd%0d_mosi_bits", k), mcap, t);
      check($sformatf("rnd%0d_rises", k), nrise, 8);
      check($sformatf("rnd%0d_done_cyc", k), d_cyc, (2 * 8 + 2) * cd + 1);
      check($sformatf("rnd%0d_busy_cyc", k), b_cyc, (2 * 8 + 2) * cd + 1 + cd);
      check($sformatf("rnd%0d_err", k), errf, 1'b0);
      check($sformatf("rnd%0d_ndone", k), ndone, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
